seqmult_dispatcher: RTL and testbench
=====================================

# seqmult_dispatcher

Operand dispatcher and result holder wrapped around the team's sequential multiplier core. It accepts operand pairs through a valid/ready input and buffers them in a small FIFO. It issues each pair to the multiplier core, holding the core's enable for the whole operation, then captures the 2N-bit product and presents it on a valid/ready output. Upstream producers can therefore stream operands without tracking multiplier latency.

## Interface
- N, 32, operand width; product width is 2N.
- DEPTH, 4, operand FIFO entries; power of two, at least 2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  an operand pair is offered.
- in_ready  out  1  FIFO can accept; `in_ready = (count != DEPTH)`.
- in_a, in_b  in  N  multiplicand and multiplier.
- mul_a, mul_b  out  N  operands to the core; registered; stable from issue until done.
- mul_en  out  1  core enable; registered.
- mul_product  in  2N  core product; valid in the cycle `mul_done` = 1.
- mul_done  in  1  one-cycle completion pulse from the core.
- out_valid  out  1  out_result holds a product.
- out_ready  in  1  consumer accepts the result.
- out_result  out  2N  captured product; registered.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  FSM is not IDLE, or count != 0.
- err_spurious  out  1  sticky flag; set by a `mul_done` pulse outside RUN.

## Operation
- FIFO behaviour:
  - Push on `in_valid & in_ready`.
  - Pop happens only in IDLE when count != 0.
  - No bypass: a pushed entry is first poppable the cycle after the push.
  - Push and pop in the same cycle leave count unchanged.
  - Write and read pointers wrap modulo DEPTH.
- FSM states: IDLE, RUN, OUT.
- IDLE:
  - If count != 0: pop the head, load it into mul_a/mul_b, set mul_en <= 1, go to RUN.
  - Otherwise stay in IDLE with mul_en = 0.
- RUN:
  - mul_en stays 1; mul_a/mul_b are unchanged.
  - On mul_done: out_result <= mul_product, out_valid <= 1, mul_en <= 0, go to OUT.
- OUT:
  - mul_en = 0.
  - When `out_valid & out_ready`: out_valid <= 0, go to IDLE.
  - out_result is held while out_ready = 0.
- Spacing guarantee: mul_en is low for at least 2 cycles between operations (OUT, then IDLE). The core requires this to re-arm.
- Spurious done: mul_done = 1 in IDLE or OUT sets err_spurious; it does not alter state or data. err_spurious clears only on reset.
- Product width: the product is 2N bits and unsigned. It is captured unmodified, with no truncation or sign handling.
- Only one operation is in flight. FIFO capacity plus the in-flight pair gives DEPTH+1 pairs accepted before in_ready falls, with no output drain.

## Timing
- Reset values: in_ready = 1, mul_a = 0, mul_b = 0, mul_en = 0, out_valid = 0, out_result = 0, count = 0, busy = 0, err_spurious = 0, FSM = IDLE, FIFO pointers = 0.
- Reset mid-operation:
  - All state clears immediately and asynchronously.
  - FIFO contents are discarded and any in-flight result is lost.
  - mul_en drops with reset; the core shares the same reset.
- Issue latency: a pair pushed at edge t into an empty FIFO with the FSM in IDLE pops at t+1. mul_en and mul_a/mul_b are valid after edge t+1.
- Result latency: out_valid rises at the edge after the cycle that samples mul_done.
- Back-to-back issue: with out_ready held at 1, the next pair's mul_en rises 2 cycles after the result is accepted (OUT, then IDLE, then RUN).
- in_ready is combinational from registered count only, with no same-cycle pop credit. When full, in_ready stays 0 for the cycle in which a pop occurs.
- Handshakes:
  - A producer holding in_valid with in_ready = 0 must keep in_a/in_b stable.
  - out_valid never drops without `out_ready = 1`.

## Test plan
- Single op: push a=3, b=5. mul_en rises 2 cycles after the push; out_result = 0x0000_0000_0000_000F; out_valid holds until out_ready.
- Max operands: push a=0xFFFFFFFF, b=0xFFFFFFFF. out_result = 0xFFFFFFFE_00000001.
- Backpressure, with out_ready = 0 and 6 push attempts:
  - Exactly DEPTH+1 = 5 pairs are accepted; in_ready is 0 after that; count = 4.
  - Release out_ready: 5 results arrive in push order, each with mul_en low ≥ 2 cycles between ops.
- Simultaneous push/pop: at count = 2, push in the IDLE pop cycle. count stays 2; ordering is preserved.
- Spurious done: pulse mul_done in IDLE. err_spurious goes to 1; FSM stays IDLE; out_valid stays 0; a following op completes correctly.
- Reset mid-RUN: assert reset while mul_en = 1 and count = 3.
  - All outputs return to reset values immediately.
  - After release, in_ready = 1, count = 0, and no stale out_valid appears.

Source files
------------

// File: rtl/seqmult_dispatcher_if.sv
// Operand, core and result channels of the sequential multiplier dispatcher.
// The dispatcher takes the slave side; the producer, core and consumer take the master side.
interface seqmult_dispatcher_if #(
  parameter int N = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic           mul_en;
  logic [2*N-1:0] mul_product;
  logic           mul_done;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_result;

  modport slave (
    input  in_valid, in_a, in_b, mul_product, mul_done, out_ready,
    output in_ready, mul_a, mul_b, mul_en, out_valid, out_result
  );

  modport master (
    output in_valid, in_a, in_b, mul_product, mul_done, out_ready,
    input  in_ready, mul_a, mul_b, mul_en, out_valid, out_result
  );
endinterface

// File: rtl/seqmult_dispatcher.sv
// Buffers operand pairs in a small FIFO, issues them one at a time to a sequential
// multiplier core and holds each 2N-bit product until the consumer accepts it.
module seqmult_dispatcher #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  seqmult_dispatcher_if.slave    bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   err_spurious
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [N-1:0]  fifo_a [DEPTH];
  logic [N-1:0]  fifo_b [DEPTH];
  logic          push;
  logic          pop;

  // No pop credit in in_ready: a full FIFO stays closed during its pop cycle.
  assign bus.in_ready = (count != CW'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = (state == IDLE) && (count != '0);
  assign busy         = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= bus.in_a;
      fifo_b[wr_ptr] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Issue / run / hold; mul_en is low through OUT and IDLE so the core can re-arm.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bus.mul_a      <= '0;
      bus.mul_b      <= '0;
      bus.mul_en     <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      err_spurious   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus.mul_a  <= fifo_a[rd_ptr];
            bus.mul_b  <= fifo_b[rd_ptr];
            bus.mul_en <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (bus.mul_done) begin
            bus.out_result <= bus.mul_product;
            bus.out_valid  <= 1'b1;
            bus.mul_en     <= 1'b0;
            state          <= OUT;
          end
        end
        OUT: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.mul_en <= 1'b0;
          state      <= IDLE;
        end
      endcase
      if (bus.mul_done && (state != RUN)) err_spurious <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seqmult_dispatcher.sv
// Bench for seqmult_dispatcher: a behavioural multiplier core with random latency,
// a product scoreboard fed from accepted pushes, vector table and directed corner cases.
module tb_seqmult_dispatcher;
  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic                   busy;
  logic                   err_spurious;

  seqmult_dispatcher_if #(.N(N)) bus ();

  seqmult_dispatcher #(.N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .count        (count),
    .busy         (busy),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q [$];
  logic [63:0] last_exp = '0;
  bit          acc = 0;
  int          rcv = 0;
  bit          core_auto = 1;
  bit          spur_req = 0;

  // Core model: after seeing mul_en, waits 0..4 cycles then pulses mul_done.
  bit core_active = 0;
  int core_cnt = 0;
  initial begin
    bus.mul_done    = 1'b0;
    bus.mul_product = '0;
    forever begin
      @(posedge clk); #2;
      bus.mul_done = 1'b0;
      if (reset) begin
        core_active = 0;
      end else if (spur_req) begin
        bus.mul_done    = 1'b1;
        bus.mul_product = 64'hBAD0_BAD0_BAD0_BAD0;
      end else if (core_active) begin
        if (core_cnt == 0) begin
          bus.mul_done    = 1'b1;
          bus.mul_product = 64'(bus.mul_a) * 64'(bus.mul_b);
          core_active     = 0;
        end else begin
          core_cnt--;
        end
      end else if (core_auto && bus.mul_en) begin
        core_active = 1;
        core_cnt    = $urandom_range(0, 4);
      end
    end
  end

  // Protocol monitor: enable spacing, operand stability, out_valid retention.
  int          low_run = 0;
  int          spacing_viol = 0;
  int          stable_viol = 0;
  int          ov_viol = 0;
  bit          seen_op = 0;
  logic        prev_en = 0;
  logic        prev_ov = 0;
  logic        prev_ordy = 0;
  logic [31:0] prev_a = 0;
  logic [31:0] prev_b = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        seen_op = 0; low_run = 0; prev_en = 0; prev_ov = 0; prev_ordy = 0;
      end else begin
        if (bus.mul_en && !prev_en) begin
          if (seen_op && low_run < 2) spacing_viol++;
          seen_op = 1;
        end
        if (bus.mul_en && prev_en && (bus.mul_a !== prev_a || bus.mul_b !== prev_b))
          stable_viol++;
        if (prev_ov && !bus.out_valid && !prev_ordy) ov_viol++;
        low_run   = bus.mul_en ? 0 : low_run + 1;
        prev_en   = bus.mul_en;
        prev_a    = bus.mul_a;
        prev_b    = bus.mul_b;
        prev_ov   = bus.out_valid;
        prev_ordy = bus.out_ready;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // One clock: sample handshakes mid-cycle, return 1 time unit after the next edge.
  task automatic cyc();
    logic [63:0] e;
    @(negedge clk);
    acc = !reset && bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(64'(bus.in_a) * 64'(bus.in_b));
    if (!reset && bus.out_valid && bus.out_ready) begin
      rcv++;
      if (exp_q.size() == 0) begin
        chk("sb_extra_result", bus.out_result, 64'hx);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        chk("sb_result", bus.out_result, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    cyc();
    for (int i = 0; i < 100 && !acc; i++) cyc();
    if (!acc) chk("push_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    for (int i = 0; i < 60 && !bus.out_valid; i++) cyc();
    if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) cyc();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] pick();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return 32'hFFFF_FFFF;
    if (s == 1) return 32'h0;
    return $urandom;
  endfunction

  vec_t tbl [8];
  int   n_acc;
  int   rcv0;
  int   ov_seen;
  logic [31:0] sa [4];

  initial begin
    tbl[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{32'h0,         32'hDEAD_BEEF, 64'h0};
    tbl[3] = '{32'h1,         32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    tbl[4] = '{32'h8000_0000, 32'h2,         64'h0000_0001_0000_0000};
    tbl[5] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001};
    tbl[6] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    tbl[7] = '{32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780};

    bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.out_ready = 0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_mul_en", bus.mul_en, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_spurious, 0);
    reset = 1'b0;
    cyc();

    // single op with issue latency and held result
    bus.in_a = 3; bus.in_b = 5; bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("so_accepted", acc, 1);
    chk("so_count_after_push", count, 1);
    chk("so_busy", busy, 1);
    chk("so_en_not_yet", bus.mul_en, 0);
    cyc();
    chk("so_en_issue", bus.mul_en, 1);
    chk("so_mul_a", bus.mul_a, 3);
    chk("so_mul_b", bus.mul_b, 5);
    chk("so_count_after_pop", count, 0);
    wait_ov();
    chk("so_result", bus.out_result, 64'hF);
    repeat (3) cyc();
    chk("so_hold_valid", bus.out_valid, 1);
    chk("so_hold_result", bus.out_result, 64'hF);
    chk("so_en_low_in_out", bus.mul_en, 0);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("so_accept_clears", bus.out_valid, 0);

    // vector table
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].a, tbl[i].b);
      wait_ov();
      chk("tbl_result", bus.out_result, tbl[i].p);
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
    end

    // backpressure: DEPTH+1 accepted with no drain
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_a = $urandom; bus.in_b = $urandom; bus.in_valid = 1'b1;
      cyc();
      if (acc) n_acc++;
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", n_acc, DEPTH + 1);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_count", count, DEPTH);
    rcv0 = rcv;
    wait_ov();
    bus.out_ready = 1'b1;
    cyc();
    chk("bp_full_idle_in_ready", bus.in_ready, 0);
    chk("bp_full_idle_count", count, DEPTH);
    cyc();
    chk("bp_pop_count", count, DEPTH - 1);
    chk("bp_pop_en", bus.mul_en, 1);
    drain();
    chk("bp_results", rcv - rcv0, DEPTH + 1);
    bus.out_ready = 1'b0;

    // push in the IDLE pop cycle at count = 2
    for (int i = 0; i < 4; i++) sa[i] = $urandom;
    push(sa[0], 32'd11);
    push(sa[1], 32'd12);
    push(sa[2], 32'd13);
    wait_ov();
    chk("pp_count_before", count, 2);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    bus.in_a = sa[3]; bus.in_b = 32'd14; bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("pp_accepted", acc, 1);
    chk("pp_count_same", count, 2);
    chk("pp_issue_en", bus.mul_en, 1);
    chk("pp_issue_order", bus.mul_a, sa[1]);
    drain();
    bus.out_ready = 1'b0;

    // spurious done in IDLE
    chk("sp_err_clear", err_spurious, 0);
    spur_req = 1;
    cyc();
    spur_req = 0;
    cyc();
    chk("sp_err_set", err_spurious, 1);
    chk("sp_out_valid", bus.out_valid, 0);
    chk("sp_idle", busy, 0);
    chk("sp_mul_en", bus.mul_en, 0);
    chk("sp_result_kept", bus.out_result, last_exp);
    push(32'd7, 32'd9);
    wait_ov();
    chk("sp_next_result", bus.out_result, 64'd63);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("sp_err_sticky", err_spurious, 1);

    // reset while running with three queued
    core_auto = 0;
    for (int i = 0; i < 4; i++) push($urandom, $urandom);
    chk("rr_mul_en", bus.mul_en, 1);
    chk("rr_count", count, 3);
    #2 reset = 1'b1;
    #1;
    chk("rr_mul_en_drop", bus.mul_en, 0);
    chk("rr_count_clear", count, 0);
    chk("rr_in_ready", bus.in_ready, 1);
    chk("rr_out_valid", bus.out_valid, 0);
    chk("rr_mul_a", bus.mul_a, 0);
    chk("rr_busy", busy, 0);
    chk("rr_err_clear", err_spurious, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    core_auto = 1;
    bus.out_ready = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (bus.out_valid || bus.mul_en) ov_seen++;
    end
    chk("rr_no_stale", ov_seen, 0);
    chk("rr_count_after", count, 0);
    chk("rr_in_ready_after", bus.in_ready, 1);

    // randomized streaming against the scoreboard
    rcv0 = rcv;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!(bus.in_valid && !acc)) begin
        bus.in_valid = ($urandom_range(0, 2) != 0);
        bus.in_a = pick();
        bus.in_b = pick();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    bus.in_valid = 1'b0;
    drain();
    chk("rand_progress", (rcv - rcv0) > 20, 1);
    chk("rand_idle", busy, 0);

    chk("mon_spacing", spacing_viol, 0);
    chk("mon_operand_stable", stable_viol, 0);
    chk("mon_out_valid_hold", ov_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
